// File: rtl/iobus_uart_tx_if.sv
// IOBUS responder port bundle: the MCU drives address, write data and strobe;
// each responder returns read data that is zero outside its own window.
interface iobus_uart_tx_if;
    logic [31:0] IOBUS_ADDR;
    logic [31:0] IOBUS_OUT;
    logic        IOBUS_WR;
    logic [31:0] IOBUS_IN;

    modport master (
        output IOBUS_ADDR,
        output IOBUS_OUT,
        output IOBUS_WR,
        input  IOBUS_IN
    );

    modport slave (
        input  IOBUS_ADDR,
        input  IOBUS_OUT,
        input  IOBUS_WR,
        output IOBUS_IN
    );
endinterface

// File: rtl/iobus_uart_tx.sv
// IOBUS-mapped 8N1 UART transmitter: DATA/STATUS/CTRL window, byte FIFO, registered TX.
// Define IOBUS_UART_TX_INT_EN to build the CTRL register and the TX_IRQ level interrupt.
module iobus_uart_tx #(
    parameter logic [31:0] BASE_ADDR  = 32'h1100_0100,
    parameter int          CLK_RATE   = 50,
    parameter int          BAUD       = 115200,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic           CLK,
    input  logic           RST_N,
    iobus_uart_tx_if.slave bus,
    output logic           TX,
    output logic           TX_IRQ
);
    // DIV must be at least 2 so the bit counter has a nonzero width
    localparam int DIV = (CLK_RATE * 1_000_000) / BAUD;
    localparam int CW  = $clog2(DIV);
    localparam int AW  = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] DIV_M1    = CW'(DIV - 1);
    localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(FIFO_DEPTH);
    localparam logic [31:0]   ADDR_DATA = BASE_ADDR;
    localparam logic [31:0]   ADDR_STAT = BASE_ADDR + 32'd4;
    localparam logic [31:0]   ADDR_CTRL = BASE_ADDR + 32'd8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;

    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW-1:0]   rptr_q, rptr_d;
    logic [AW:0]     count_q, count_d;
    logic            ovf_q, ovf_d;

    logic            hit_data, hit_stat, hit_ctrl;
    logic            wr_data, wr_stat;
    logic            full, empty, busy;
    logic            push, pop;
    logic [7:0]      head;
    logic [31:0]     status_w, ctrl_rd, rd_data;
    logic            unused_out;

    assign hit_data = (bus.IOBUS_ADDR == ADDR_DATA);
    assign hit_stat = (bus.IOBUS_ADDR == ADDR_STAT);
    assign hit_ctrl = (bus.IOBUS_ADDR == ADDR_CTRL);
    assign wr_data  = bus.IOBUS_WR & hit_data;
    assign wr_stat  = bus.IOBUS_WR & hit_stat;

    assign unused_out = ^bus.IOBUS_OUT[31:8];

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);
    assign busy  = ~empty | (state_q != S_IDLE);
    assign head  = mem_q[rptr_q];

    // A push into a full FIFO is only accepted when the FSM frees a slot in the same cycle
    assign push = wr_data & (~full | pop);

    always_comb begin
        ovf_d = ovf_q;
        if (wr_data && full && !pop) begin
            ovf_d = 1'b1;
        end else if (wr_stat && bus.IOBUS_OUT[3]) begin
            ovf_d = 1'b0;
        end
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (push) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // tx_d is the line level for the state being entered, so TX changes with the state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    cnt_d   = DIV_M1;
                    tx_d    = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == '0) begin
                    cnt_d   = DIV_M1;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                    state_d = S_DATA;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DATA: begin
                if (cnt_q == '0) begin
                    cnt_d = DIV_M1;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_STOP: begin
                if (cnt_q == '0) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = head;
                        cnt_d   = DIV_M1;
                        tx_d    = 1'b0;
                        state_d = S_START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wptr_q] <= bus.IOBUS_OUT[7:0];
        end
    end

    assign TX = tx_q;

`ifdef IOBUS_UART_TX_INT_EN
    logic irq_en_q, irq_en_d;
    logic irq_q, irq_d;
    logic wr_ctrl;

    assign wr_ctrl = bus.IOBUS_WR & hit_ctrl;

    always_comb begin
        irq_en_d = irq_en_q;
        if (wr_ctrl) begin
            irq_en_d = bus.IOBUS_OUT[0];
        end
        irq_d = irq_en_q & empty & (state_q == S_IDLE);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end

    assign ctrl_rd = {31'd0, irq_en_q};
    assign TX_IRQ  = irq_q;
`else
    assign ctrl_rd = '0;
    assign TX_IRQ  = 1'b0;
`endif

    assign status_w = {17'd0, 7'(count_q), 4'd0, ovf_q, empty, full, busy};

    // Zero outside the window (and while in reset) so responders can be OR-ed together
    always_comb begin
        rd_data = '0;
        if (RST_N) begin
            if (hit_stat) begin
                rd_data = status_w;
            end else if (hit_ctrl) begin
                rd_data = ctrl_rd;
            end
        end
    end

    assign bus.IOBUS_IN = rd_data;

endmodule

// File: tb/tb_iobus_uart_tx.sv
// Directed bench for iobus_uart_tx (DIV=4, FIFO_DEPTH=4): a TX-line decoder pops expected
// bytes from a scoreboard queue; STATUS, latency, decode and interrupt behaviour are checked inline.
module tb_iobus_uart_tx;
    localparam logic [31:0] BASE  = 32'h1100_0100;
    localparam int          DIV   = 4;
    localparam int          FRAME = 10 * DIV;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tx;
    logic irq;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [7:0] exp_q[$];
    int         starts[$];
    logic       line_v [FRAME];

    iobus_uart_tx_if bus();

    iobus_uart_tx #(
        .BASE_ADDR (BASE),
        .CLK_RATE  (1),
        .BAUD      (250000),
        .FIFO_DEPTH(4)
    ) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus),
        .TX    (tx),
        .TX_IRQ(irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        bus.IOBUS_ADDR = a;
        bus.IOBUS_OUT  = d;
        bus.IOBUS_WR   = 1'b1;
        @(posedge clk);
        #1;
        bus.IOBUS_WR   = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        bus.IOBUS_ADDR = a;
        bus.IOBUS_WR   = 1'b0;
        #1;
        d = bus.IOBUS_IN;
    endtask

    task automatic wait_idle(input int max_cyc, input string tag);
        logic [31:0] s;
        int n;
        n = 0;
        bus_read(BASE + 32'd4, s);
        while (s[0] && n < max_cyc) begin
            @(posedge clk);
            #1;
            bus_read(BASE + 32'd4, s);
            n++;
        end
        check({tag, "_idle"}, 32'(s[0]), 32'd0);
    endtask

    task automatic watch_line_high(input int n_cyc, input string tag);
        bit all_high;
        all_high = 1'b1;
        for (int i = 0; i < n_cyc; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) all_high = 1'b0;
        end
        check(tag, 32'(all_high), 32'd1);
    endtask

    // TX line decoder: sample every cycle of a frame on the falling edge
    initial begin : monitor
        logic [7:0] byte_v;
        logic [7:0] exp_b;
        bit ok_start, ok_bits, ok_stop, aborted;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx === 1'b0) begin
                starts.push_back(cyc);
                aborted   = 1'b0;
                line_v[0] = tx;
                for (int j = 1; j < FRAME; j++) begin
                    @(negedge clk);
                    if (rst_n !== 1'b1) aborted = 1'b1;
                    line_v[j] = tx;
                end
                if (!aborted) begin
                    ok_start = 1'b1;
                    ok_stop  = 1'b1;
                    ok_bits  = 1'b1;
                    for (int k = 0; k < DIV; k++) begin
                        if (line_v[k] !== 1'b0) ok_start = 1'b0;
                        if (line_v[9 * DIV + k] !== 1'b1) ok_stop = 1'b0;
                    end
                    for (int b = 0; b < 8; b++) begin
                        byte_v[b] = line_v[DIV * (b + 1)];
                        for (int k = 1; k < DIV; k++) begin
                            if (line_v[DIV * (b + 1) + k] !== line_v[DIV * (b + 1)]) ok_bits = 1'b0;
                        end
                    end
                    check("start_bit_width", 32'(ok_start), 32'd1);
                    check("data_bit_width", 32'(ok_bits), 32'd1);
                    check("stop_bit_width", 32'(ok_stop), 32'd1);
                    if (exp_q.size() == 0) begin
                        check("frame_expected", 32'(exp_q.size()), 32'd1);
                    end else begin
                        exp_b = exp_q.pop_front();
                        check("frame_byte", 32'(byte_v), 32'(exp_b));
                    end
                end
            end
        end
    end

`ifndef IOBUS_UART_TX_INT_EN
    bit irq_seen = 1'b0;
    always @(negedge clk) begin
        if (irq !== 1'b0) irq_seen <= 1'b1;
    end
`endif

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [31:0] rd;
        int t0;

        bus.IOBUS_ADDR = '0;
        bus.IOBUS_OUT  = '0;
        bus.IOBUS_WR   = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_irq", 32'(irq), 32'd0);
        bus_read(BASE + 32'd4, rd);
        check("rst_status_zero", rd, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        bus_read(BASE + 32'd4, rd);
        check("status_after_reset", rd, 32'h0000_0004);

        // single byte 0x55
        starts.delete();
        exp_q.push_back(8'h55);
        bus_write(BASE, 32'h55);
        t0 = cyc;
        bus_read(BASE + 32'd4, rd);
        check("status_after_push", rd, 32'h0000_0101);
        repeat (20) @(posedge clk);
        #1;
        bus_read(BASE + 32'd4, rd);
        check("status_mid_frame", rd, 32'h0000_0005);
        wait_idle(60, "single");
        check("single_latency", 32'((starts.size() > 0) ? starts[0] - t0 : -1), 32'd1);
        check("single_frames", 32'(starts.size()), 32'd1);
        check("single_sb_empty", 32'(exp_q.size()), 32'd0);
        bus_read(BASE + 32'd4, rd);
        check("single_status_done", rd, 32'h0000_0004);

        // back-to-back 0xA5, 0x3C
        starts.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h3C);
        bus_write(BASE, 32'hA5);
        t0 = cyc;
        bus_write(BASE, 32'h3C);
        wait_idle(120, "b2b");
        check("b2b_frames", 32'(starts.size()), 32'd2);
        check("b2b_latency", 32'((starts.size() > 0) ? starts[0] - t0 : -1), 32'd1);
        check("b2b_no_gap", 32'((starts.size() > 1) ? starts[1] - starts[0] : -1), 32'(FRAME));
        check("b2b_sb_empty", 32'(exp_q.size()), 32'd0);

        // overflow: six writes into a depth-4 FIFO
        starts.delete();
        for (int i = 1; i <= 6; i++) begin
            if (i <= 5) exp_q.push_back(8'(i));
            bus_write(BASE, 32'(i));
            if (i == 1) t0 = cyc;
        end
        bus_read(BASE + 32'd4, rd);
        check("ovf_status", rd, 32'h0000_040B);
        bus_write(BASE + 32'd4, 32'h8);
        bus_read(BASE + 32'd4, rd);
        check("ovf_cleared", rd, 32'h0000_0403);
        wait_idle(5 * FRAME + 20, "ovf");
        check("ovf_frames", 32'(starts.size()), 32'd5);
        check("ovf_latency", 32'((starts.size() > 0) ? starts[0] - t0 : -1), 32'd1);
        check("ovf_no_gaps", 32'((starts.size() > 4) ? starts[4] - starts[0] : -1), 32'(4 * FRAME));
        check("ovf_sb_empty", 32'(exp_q.size()), 32'd0);

        // reset during data bit 3 of 0xFF
        starts.delete();
        exp_q.push_back(8'hFF);
        bus_write(BASE, 32'hFF);
        repeat (18) @(posedge clk);
        #1;
        check("pre_reset_busy", 32'(tx), 32'd1);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("reset_tx_high", 32'(tx), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        bus_read(BASE + 32'd4, rd);
        check("reset_status", rd, 32'h0000_0004);
        watch_line_high(50, "reset_line_idle");
        check("reset_started_once", 32'(starts.size()), 32'd1);

        // address decode
        starts.delete();
        bus_write(BASE + 32'd16, 32'h77);
        bus_write(32'h1100_0000, 32'h77);
        bus_write(BASE + 32'd12, 32'h77);
        watch_line_high(30, "decode_line_idle");
        check("decode_no_frames", 32'(starts.size()), 32'd0);
        bus_read(BASE + 32'd16, rd);
        check("decode_rd_plus16", rd, 32'h0);
        bus_read(32'h1100_0000, rd);
        check("decode_rd_other", rd, 32'h0);
        bus_read(BASE, rd);
        check("decode_rd_data", rd, 32'h0);
        bus_read(BASE + 32'd12, rd);
        check("decode_rd_plus12", rd, 32'h0);
        bus_read(BASE + 32'd4, rd);
        check("decode_status", rd, 32'h0000_0004);

`ifdef IOBUS_UART_TX_INT_EN
        bus_write(BASE + 32'd8, 32'h1);
        bus_read(BASE + 32'd8, rd);
        check("ctrl_readback", rd, 32'h1);
        exp_q.push_back(8'h00);
        bus_write(BASE, 32'h00);
        repeat (10) @(posedge clk);
        #1;
        check("irq_during_frame", 32'(irq), 32'd0);
        wait_idle(60, "irq");
        check("irq_at_idle_edge", 32'(irq), 32'd0);
        @(posedge clk);
        #1;
        check("irq_after_idle", 32'(irq), 32'd1);
        bus_write(BASE + 32'd8, 32'h0);
        @(posedge clk);
        #1;
        check("irq_cleared", 32'(irq), 32'd0);
        check("irq_sb_empty", 32'(exp_q.size()), 32'd0);
`else
        bus_write(BASE + 32'd8, 32'h1);
        bus_read(BASE + 32'd8, rd);
        check("ctrl_reads_zero", rd, 32'h0);
        exp_q.push_back(8'h00);
        bus_write(BASE, 32'h00);
        wait_idle(60, "noirq");
        repeat (3) @(posedge clk);
        #1;
        check("noirq_sb_empty", 32'(exp_q.size()), 32'd0);
        check("irq_never_set", 32'(irq_seen), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
